// File: rtl/tof_pkg.sv
// Shared constants and types for the ToF write path.
package tof_pkg;

   localparam int N_TOF = 8;
   localparam int IDX_W = 3;

   typedef logic [IDX_W-1:0] tof_idx_t;
   typedef logic [N_TOF-1:0] tof_mask_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      WRITE  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr wins.
module rr_arbiter
   import tof_pkg::*;
(
   input  tof_mask_t req,
   input  tof_idx_t  ptr,
   output tof_idx_t  grant,
   output logic      valid
);

   tof_idx_t idx;

   // Scan from the farthest offset back to ptr so the nearest request is written last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = N_TOF - 1; i >= 0; i--) begin
         idx = ptr + tof_idx_t'(i);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_write_fsm.sv
// Turns ToF data-ready edges into single-cycle BRAM write pulses, one sensor at a time.
//   state  | meaning
//   IDLE   | waiting for a pending event; ToF_Index holds last value
//   SELECT | ToF_Index driven, front-end mux settling
//   WRITE  | wea high for one cycle, pending bit cleared on exit
module mem_write_fsm
   import tof_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_TOF-1:0] ToF_dr,
   output logic             wea,
   output logic [IDX_W-1:0] ToF_Index,
   output logic [N_TOF-1:0] ToF_overrun
);

   wr_state_t  state;
   tof_mask_t  dr_prev;
   tof_mask_t  pending;
   tof_idx_t   ptr;
   logic [1:0] settle_cnt;

   tof_mask_t  rise;
   tof_mask_t  clr;
   tof_idx_t   grant_idx;
   logic       grant_vld;

   always_comb begin
      rise = ToF_dr & ~dr_prev;
      clr  = '0;
      if (state == WRITE) clr[ToF_Index] = 1'b1;
   end

   rr_arbiter u_arb (
      .req   (pending),
      .ptr   (ptr),
      .grant (grant_idx),
      .valid (grant_vld)
   );

   always_ff @(posedge clk) begin
      // Edge history keeps following the inputs through reset, so a line already
      // high when reset releases is not mistaken for a fresh event.
      dr_prev <= ToF_dr;
      if (!reset) begin
         state       <= IDLE;
         pending     <= '0;
         ptr         <= '0;
         settle_cnt  <= '0;
         wea         <= 1'b0;
         ToF_Index   <= '0;
         ToF_overrun <= '0;
      end else begin
         // A new edge on the bit being retired wins over the clear and is not an overrun.
         pending     <= (pending & ~clr) | rise;
         ToF_overrun <= ToF_overrun | (rise & pending & ~clr);
         wea         <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  ToF_Index  <= grant_idx;
                  settle_cnt <= 2'(SETTLE_CYCLES - 1);
                  state      <= SELECT;
               end
            end
            SELECT: begin
               if (settle_cnt == 2'd0) begin
                  state <= WRITE;
                  wea   <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - 2'd1;
               end
            end
            WRITE: begin
               ptr   <= tof_idx_t'(ToF_Index + 1'b1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_fsm.sv
// Directed bench for mem_write_fsm: reset, single event, round-robin, overrun, mid-write reset.
module tb_mem_write_fsm;

   logic       clk;
   logic       reset;
   logic [7:0] ToF_dr;
   logic       wea;
   logic [2:0] ToF_Index;
   logic [7:0] ToF_overrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr_idx[$];
   int wr_cyc[$];

   mem_write_fsm #(.SETTLE_CYCLES(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .ToF_dr      (ToF_dr),
      .wea         (wea),
      .ToF_Index   (ToF_Index),
      .ToF_overrun (ToF_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge and logging write pulses.
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         if (wea === 1'b1) begin
            wr_idx.push_back(int'(ToF_Index));
            wr_cyc.push_back(cyc);
         end
      end
   endtask

   int t0;

   initial begin
      reset  = 1'b0;
      ToF_dr = 8'hFF;

      // Reset with all lines high, then release without any rising edge
      run(3);
      chk("rst_wea", 32'(wea), 32'd0);
      chk("rst_idx", 32'(ToF_Index), 32'd0);
      chk("rst_ovr", 32'(ToF_overrun), 32'd0);
      reset = 1'b1;
      run(8);
      chk("rst_release_no_write", 32'(wr_idx.size()), 32'd0);

      // Single event on sensor 5, held high for 20 cycles
      ToF_dr = 8'h00;
      run(2);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'h20;
      run(1);
      chk("single_e0_wea", 32'(wea), 32'd0);
      run(1);
      chk("single_e1_idx", 32'(ToF_Index), 32'd5);
      chk("single_e1_wea", 32'(wea), 32'd0);
      run(1);
      chk("single_e2_wea", 32'(wea), 32'd1);
      chk("single_e2_idx", 32'(ToF_Index), 32'd5);
      run(1);
      chk("single_e3_wea", 32'(wea), 32'd0);
      chk("single_e3_idx", 32'(ToF_Index), 32'd5);
      run(20);
      chk("single_pulses", 32'(wr_idx.size()), 32'd1);

      // Fresh reset, then four simultaneous edges
      ToF_dr = 8'h00;
      reset  = 1'b0;
      run(2);
      reset  = 1'b1;
      run(2);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'b1010_0101;
      t0 = cyc + 1;
      run(16);
      chk("sim_count", 32'(wr_idx.size()), 32'd4);
      if (wr_idx.size() == 4) begin
         chk("sim_idx0", 32'(wr_idx[0]), 32'd0);
         chk("sim_idx1", 32'(wr_idx[1]), 32'd2);
         chk("sim_idx2", 32'(wr_idx[2]), 32'd5);
         chk("sim_idx3", 32'(wr_idx[3]), 32'd7);
         chk("sim_latency", 32'(wr_cyc[0] - t0), 32'd2);
         chk("sim_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
         chk("sim_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd3);
         chk("sim_gap3", 32'(wr_cyc[3] - wr_cyc[2]), 32'd3);
      end

      // Round-robin: serve 6, then 1 and 7 together -> 7 first
      ToF_dr = 8'h00;
      run(3);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'h40;
      run(6);
      ToF_dr = 8'hC2;
      run(10);
      chk("rr_count", 32'(wr_idx.size()), 32'd3);
      if (wr_idx.size() == 3) begin
         chk("rr_first", 32'(wr_idx[0]), 32'd6);
         chk("rr_second", 32'(wr_idx[1]), 32'd7);
         chk("rr_third", 32'(wr_idx[2]), 32'd1);
      end

      // Set wins: new edge on bit 3 lands on its own WRITE exit edge
      ToF_dr = 8'h00;
      run(3);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'h08;
      run(1);
      ToF_dr = 8'h00;
      run(2);
      ToF_dr = 8'h08;
      run(1);
      run(8);
      chk("setwin_count", 32'(wr_idx.size()), 32'd2);
      if (wr_idx.size() == 2) begin
         chk("setwin_idx0", 32'(wr_idx[0]), 32'd3);
         chk("setwin_idx1", 32'(wr_idx[1]), 32'd3);
      end
      chk("setwin_no_ovr", 32'(ToF_overrun), 32'd0);

      // Overrun: second edge on bit 3 while it is still pending (during SELECT)
      ToF_dr = 8'h00;
      run(3);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'h08;
      run(1);
      ToF_dr = 8'h00;
      run(1);
      ToF_dr = 8'h08;
      run(1);
      run(8);
      chk("ovr_count", 32'(wr_idx.size()), 32'd1);
      chk("ovr_flags", 32'(ToF_overrun), 32'h08);
      run(4);
      chk("ovr_sticky", 32'(ToF_overrun), 32'h08);

      // Mid-write reset during SELECT with three events pending
      ToF_dr = 8'h00;
      run(3);
      wr_idx.delete(); wr_cyc.delete();
      ToF_dr = 8'h70;
      run(2);
      chk("midrst_select_idx", 32'(ToF_Index), 32'd4);
      reset = 1'b0;
      run(1);
      chk("midrst_wea", 32'(wea), 32'd0);
      chk("midrst_idx", 32'(ToF_Index), 32'd0);
      chk("midrst_ovr", 32'(ToF_overrun), 32'd0);
      reset = 1'b1;
      run(10);
      chk("midrst_no_write", 32'(wr_idx.size()), 32'd0);

      // A genuine new edge after that reset is still serviced
      ToF_dr = 8'h00;
      run(2);
      ToF_dr = 8'h02;
      run(6);
      chk("post_rst_count", 32'(wr_idx.size()), 32'd1);
      if (wr_idx.size() == 1) chk("post_rst_idx", 32'(wr_idx[0]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
